// File: rtl/id_pipe_stage_if.sv
// rtl/id_pipe_stage_if.sv - ID/EX pipeline register bus with valid/ready handshake
interface id_pipe_stage_if #(
  parameter int ARQ     = 16,
  parameter int RW      = 3,
  parameter int JADDR_W = 13
);
  logic               out_valid;
  logic               out_ready;
  logic [ARQ-1:0]     out1;
  logic [ARQ-1:0]     out2;
  logic [ARQ-1:0]     out3;
  logic [ARQ-1:0]     imm;
  logic [JADDR_W-1:0] addr;
  logic [2:0]         opcode;
  logic [RW-1:0]      rd_out;
  logic               jop_lsb;

  modport master (
    output out_valid, out1, out2, out3, imm, addr, opcode, rd_out, jop_lsb,
    input  out_ready
  );

  modport slave (
    input  out_valid, out1, out2, out3, imm, addr, opcode, rd_out, jop_lsb,
    output out_ready
  );
endinterface

// File: rtl/id_pipe_stage.sv
// rtl/id_pipe_stage.sv - decode stage: field decode, 3-read register bank, ID/EX register
// Optional macro ID_FWD_EN bypasses same-cycle writeback data onto the read ports.
module id_pipe_stage #(
  parameter int         ARQ     = 16,
  parameter int         NREG    = 8,
  parameter int         IMM_W   = 10,
  parameter int         JADDR_W = 13,
  parameter logic [2:0] LOAD_OP = 3'b100,
  localparam int        RW      = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ARQ-1:0]           instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     wb_enable,
  input  logic [RW-1:0]            wb_addr,
  input  logic [ARQ-1:0]           wb_result,
  input  logic                     cntrl_mux,
  id_pipe_stage_if.master          ex
);

  logic [2:0]     opcode_d;
  logic [RW-1:0]  rd_d;
  logic [RW-1:0]  rs1_d;
  logic [RW-1:0]  rs2_d;
  logic [ARQ-1:0] imm_d;
  logic [JADDR_W-1:0] addr_d;

  // Fields overlap on purpose; the execute stage picks the format from the opcode.
  assign opcode_d = instr[ARQ-1 -: 3];
  assign rd_d     = instr[ARQ-4 -: RW];
  assign rs1_d    = instr[ARQ-4-RW -: RW];
  assign rs2_d    = instr[ARQ-4-2*RW -: RW];
  assign imm_d    = {{(ARQ-IMM_W){1'b0}}, instr[IMM_W-1:0]};
  assign addr_d   = instr[JADDR_W-1:0];

  logic [ARQ-1:0] bank [NREG];
  logic [ARQ-1:0] wdata;
  logic [ARQ-1:0] rdata1;
  logic [ARQ-1:0] rdata2;
  logic [ARQ-1:0] rdata3;

  assign wdata = cntrl_mux ? wb_result : imm_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
    end else if (wb_enable) begin
      bank[wb_addr] <= wdata;
    end
  end

`ifdef ID_FWD_EN
  assign rdata1 = (wb_enable && wb_addr == rd_d)  ? wdata : bank[rd_d];
  assign rdata2 = (wb_enable && wb_addr == rs1_d) ? wdata : bank[rs1_d];
  assign rdata3 = (wb_enable && wb_addr == rs2_d) ? wdata : bank[rs2_d];
`else
  assign rdata1 = bank[rd_d];
  assign rdata2 = bank[rs1_d];
  assign rdata3 = bank[rs2_d];
`endif

  logic hazard;
  logic accept;

  // A load still in ID/EX cannot feed any field of the incoming instruction.
  assign hazard = in_valid && ex.out_valid && (ex.opcode == LOAD_OP) &&
                  (ex.rd_out == rd_d || ex.rd_out == rs1_d || ex.rd_out == rs2_d);
  assign in_ready = !flush && !hazard && (!ex.out_valid || ex.out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex.out_valid <= 1'b0;
      ex.out1      <= '0;
      ex.out2      <= '0;
      ex.out3      <= '0;
      ex.imm       <= '0;
      ex.addr      <= '0;
      ex.opcode    <= '0;
      ex.rd_out    <= '0;
      ex.jop_lsb   <= 1'b0;
    end else if (accept) begin
      ex.out_valid <= 1'b1;
      ex.out1      <= rdata1;
      ex.out2      <= rdata2;
      ex.out3      <= rdata3;
      ex.imm       <= imm_d;
      ex.addr      <= addr_d;
      ex.opcode    <= opcode_d;
      ex.rd_out    <= rd_d;
      ex.jop_lsb   <= opcode_d[0];
    end else if (flush || ex.out_ready) begin
      ex.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// tb/tb_id_pipe_stage.sv - directed self-checking bench for id_pipe_stage
module tb_id_pipe_stage;
  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        wb_enable;
  logic [2:0]  wb_addr;
  logic [15:0] wb_result;
  logic        cntrl_mux;

  int total;
  int bad;

`ifdef ID_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_pipe_stage_if #(.ARQ(16), .RW(3), .JADDR_W(13)) ex_if ();

  id_pipe_stage dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .wb_enable (wb_enable),
    .wb_addr   (wb_addr),
    .wb_result (wb_result),
    .cntrl_mux (cntrl_mux),
    .ex        (ex_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2,
                                     input logic [3:0] lo);
    return {op, rd, rs1, rs2, lo};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    instr = '0; in_valid = 0; flush = 0;
    wb_enable = 0; wb_addr = '0; wb_result = '0; cntrl_mux = 0;
    ex_if.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", ex_if.out_valid, 0);
    chk("rst_out1", ex_if.out1, 0);
    chk("rst_out2", ex_if.out2, 0);
    chk("rst_out3", ex_if.out3, 0);
    chk("rst_imm", ex_if.imm, 0);
    chk("rst_addr", ex_if.addr, 0);
    chk("rst_opcode", ex_if.opcode, 0);
    chk("rst_rd_out", ex_if.rd_out, 0);
    chk("rst_jop_lsb", ex_if.jop_lsb, 0);
    chk("rst_in_ready", in_ready, 1);
    cycle();
    rst = 1'b0;

    // back-to-back reads of every register after reset
    ex_if.out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr = mk(3'b000, 3'(i), 3'(i), 3'(i), 4'h0);
      cycle();
      chk($sformatf("rd0_valid_%0d", i), ex_if.out_valid, 1);
      chk($sformatf("rd0_out1_%0d", i), ex_if.out1, 0);
      chk($sformatf("rd0_out2_%0d", i), ex_if.out2, 0);
      chk($sformatf("rd0_rdout_%0d", i), ex_if.rd_out, i);
    end

    // writeback of wb_result into R3, then read via rs1
    in_valid = 0;
    wb_enable = 1; wb_addr = 3'd3; cntrl_mux = 1; wb_result = 16'hBEEF;
    cycle();
    chk("bubble_valid", ex_if.out_valid, 0);
    wb_enable = 0;
    in_valid = 1; instr = mk(3'b000, 3'd1, 3'd3, 3'd0, 4'h0);
    cycle();
    chk("beef_valid", ex_if.out_valid, 1);
    chk("beef_out2", ex_if.out2, 32'hBEEF);

    // immediate writeback into R5 on the same edge as reading R5 via rd
    wb_enable = 1; wb_addr = 3'd5; cntrl_mux = 0;
    instr = {3'b001, 3'd5, 10'h3FF};
    cycle();
    chk("imm_out", ex_if.imm, 32'h03FF);
    chk("imm_addr", ex_if.addr, 32'h17FF);
    chk("imm_opcode", ex_if.opcode, 1);
    chk("imm_jop_lsb", ex_if.jop_lsb, 1);
    chk("imm_same_cycle_out1", ex_if.out1, FWD ? 32'h03FF : 32'h0);
    wb_enable = 0;
    instr = mk(3'b000, 3'd5, 3'd0, 3'd0, 4'h0);
    cycle();
    chk("r5_readback", ex_if.out1, 32'h03FF);

    // load-use hazard on rs2
    instr = mk(3'b100, 3'd2, 3'd0, 3'd0, 4'h0);
    cycle();
    chk("load_valid", ex_if.out_valid, 1);
    chk("load_opcode", ex_if.opcode, 4);
    instr = mk(3'b000, 3'd1, 3'd0, 3'd2, 4'h0);
    #1;
    chk("hazard_in_ready", in_ready, 0);
    cycle();
    chk("hazard_bubble", ex_if.out_valid, 0);
    #1;
    chk("after_bubble_in_ready", in_ready, 1);
    cycle();
    chk("hazard_accept_valid", ex_if.out_valid, 1);
    chk("hazard_accept_rd", ex_if.rd_out, 1);
    chk("hazard_accept_opcode", ex_if.opcode, 0);

    // backpressure holds the register, then flush clears it
    ex_if.out_ready = 0;
    instr = mk(3'b010, 3'd6, 3'd0, 3'd0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_in_ready_%0d", i), in_ready, 0);
      cycle();
      chk($sformatf("stall_valid_%0d", i), ex_if.out_valid, 1);
      chk($sformatf("stall_rd_%0d", i), ex_if.rd_out, 1);
      chk($sformatf("stall_opcode_%0d", i), ex_if.opcode, 0);
    end
    flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    cycle();
    chk("flush_valid", ex_if.out_valid, 0);
    chk("flush_rd_hold", ex_if.rd_out, 1);

    // flush with a simultaneous write: the write must still land
    ex_if.out_ready = 1;
    wb_enable = 1; wb_addr = 3'd6; cntrl_mux = 1; wb_result = 16'h5A5A;
    cycle();
    chk("flush_wb_valid", ex_if.out_valid, 0);
    flush = 0; wb_enable = 0;
    instr = mk(3'b000, 3'd6, 3'd0, 3'd0, 4'h0);
    cycle();
    chk("flush_wb_r6", ex_if.out1, 32'h5A5A);

    // same-cycle write and read of R4 through rs1
    wb_enable = 1; wb_addr = 3'd4; cntrl_mux = 1; wb_result = 16'h1234;
    instr = mk(3'b000, 3'd0, 3'd4, 3'd0, 4'h0);
    cycle();
    chk("same_cycle_out2", ex_if.out2, FWD ? 32'h1234 : 32'h0);
    wb_enable = 0;
    cycle();
    chk("next_cycle_out2", ex_if.out2, 32'h1234);

    in_valid = 0;
    cycle();
    chk("drain_valid", ex_if.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Parametrised instruction-decode stage for the ARQ-bit core. It decodes one instruction per cycle, reads three operands from an NREG×ARQ register bank, and accepts writebacks of either the zero-extended immediate or the writeback result. Decoded fields and operands are registered into an ID/EX pipeline register with a valid/ready handshake, load-use stall detection and flush. It sits between the fetch stage and the execute stage.

## Interface
- ARQ, 16, datapath and instruction width (≥16)
- NREG, 8, number of registers (power of 2, ≥2); RW = $clog2(NREG)
- IMM_W, 10, immediate field width (< ARQ)
- JADDR_W, 13, jump address width (≤ ARQ-3)
- LOAD_OP, 3'b100, opcode value treated as a load for hazard detection

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  ARQ  instruction from fetch
- in_valid  in  1  instr is valid
- in_ready  out  1  stage accepts instr this cycle
- flush  in  1  discard the pipeline register and the current input
- wb_enable  in  1  register write strobe
- wb_addr  in  RW  register write address
- wb_result  in  ARQ  writeback data
- cntrl_mux  in  1  write data select: 0 = zero-extended imm of the current instr, 1 = wb_result
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  execute consumes the register this cycle
- out1, out2, out3  out  ARQ  registered R[rd], R[rs1], R[rs2]
- imm  out  ARQ  registered zero-extended immediate
- addr  out  JADDR_W  registered jump address
- opcode  out  3  registered opcode
- rd_out  out  RW  registered destination field
- jop_lsb  out  1  registered opcode[0]

## Operation
- Field decode, combinational: opcode = instr[ARQ-1:ARQ-3]; rd = instr[ARQ-4 -: RW]; rs1 = next RW bits below it; rs2 = next RW bits below that; imm = zero-extend(instr[IMM_W-1:0]); addr = instr[JADDR_W-1:0]. Fields overlap by design; the format is chosen by opcode downstream.
- Register bank: NREG entries, all read combinationally through 3 ports. On rising edge with wb_enable, R[wb_addr] ← (cntrl_mux ? wb_result : imm). Register 0 is an ordinary register.
- hazard = in_valid && out_valid && opcode_q==LOAD_OP && rd_out ∈ {rd, rs1, rs2} of instr.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- accept = in_valid && in_ready: the pipeline register loads all outputs, and out_valid ← 1.
- Otherwise: if flush, out_valid ← 0; else if out_ready, out_valid ← 0 (bubble). Data fields hold their values when not accepting.
- Hazard stall: the load drains when out_ready, a bubble follows, and instr is accepted on the next cycle.
- A register written on the same edge that a reading instruction is accepted: the result depends on ID_FWD_EN.

## Timing
- Reset (asynchronous): all registers 0, out_valid 0, and all registered outputs 0. in_ready follows its combinational equation after reset.
- Latency: 1 cycle from accept to outputs visible with out_valid=1.
- Throughput: 1 instr/cycle while out_ready=1 and there is no hazard.
- The writeback is visible to a combinational read on the cycle after its edge, and in the same cycle when ID_FWD_EN is defined.
- Flush takes priority over accept and hazard. If flush and wb_enable are asserted together, the write still occurs.
- in_ready does not depend on out_valid alone when out_ready=1, so the pipeline register never holds a stale bubble.

## Configuration
- ID_FWD_EN defined: each read port is bypassed, so when wb_enable && wb_addr==read address, the port returns the write data (cntrl_mux-selected) in the same cycle.
- ID_FWD_EN undefined: ports return the pre-write bank contents, and software must space dependent instructions by one cycle.

## Test plan
- Reset with outputs at X → all outputs 0 and out_valid 0. After release, reading R0–R7 returns 0.
- wb_enable, wb_addr=3, cntrl_mux=1, wb_result=16'hBEEF, then instr reading rs1=3 → out2=16'hBEEF one cycle after accept.
- cntrl_mux=0, instr[9:0]=10'h3FF, wb_addr=5 → R5=16'h03FF; imm output =16'h03FF.
- Load (opcode 100, rd=2) accepted, next instr has rs2=2 → in_ready=0 for one cycle, one bubble with out_valid=0, then the instr is accepted.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. flush then gives out_valid=0 on the next edge.
- Same-cycle write to R4=16'h1234 and read of rs1=4 → out2=16'h1234 with ID_FWD_EN, old value without it.
